// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with debounce and 4-digit BCD entry register.
// Columns are driven low one at a time. Rows are sampled at the end of each
// column dwell. A full scan is classified as NONE, ONE(code) or MULTI, and a
// four-state FSM accepts each debounced press exactly once.
module keypad_bcd_entry #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hund,
  output logic [3:0] thous,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned      DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       cidx_q, cidx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      hits_q, hits_d, hits_now;
  logic             col_last, scan_done;
  logic [4:0]       n_hits;
  logic [3:0]       hit_code;
  logic             res_none, res_one;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             accept_c;
  logic [3:0]       units_q, tens_q, hund_q, thous_q;
  logic [3:0]       units_d, tens_d, hund_d, thous_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;

  // Key position {row, col} to key code.
  function automatic logic [3:0] code_of(input logic [3:0] pos);
    case (pos)
      4'd0:    code_of = 4'h1;
      4'd1:    code_of = 4'h2;
      4'd2:    code_of = 4'h3;
      4'd3:    code_of = 4'hA;
      4'd4:    code_of = 4'h4;
      4'd5:    code_of = 4'h5;
      4'd6:    code_of = 4'h6;
      4'd7:    code_of = 4'hB;
      4'd8:    code_of = 4'h7;
      4'd9:    code_of = 4'h8;
      4'd10:   code_of = 4'h9;
      4'd11:   code_of = 4'hC;
      4'd12:   code_of = 4'hE;
      4'd13:   code_of = 4'h0;
      4'd14:   code_of = 4'hF;
      default: code_of = 4'hD;
    endcase
  endfunction

  assign col_last  = (div_q == DIV_LAST);
  assign scan_done = col_last && (cidx_q == 2'd3);

  // Hit map including the column currently being sampled.
  always_comb begin
    hits_now = hits_q;
    for (int r = 0; r < 4; r++) begin
      hits_now[{2'(r), cidx_q}] = ~row_s2_q[r];
    end
  end

  // Classify the hit map: count of keys seen and code of one of them.
  always_comb begin
    n_hits   = '0;
    hit_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits_now[i]) begin
        n_hits   = n_hits + 5'd1;
        hit_code = code_of(4'(i));
      end
    end
  end

  assign res_none = (n_hits == 5'd0);
  assign res_one  = (n_hits == 5'd1);

  // Column divider, rotation and hit accumulation.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    cidx_d = cidx_q;
    col_d  = col_q;
    hits_d = hits_q;
    if (col_last) begin
      div_d  = '0;
      cidx_d = cidx_q + 2'd1;
      col_d  = {col_q[2:0], col_q[3]};
      hits_d = scan_done ? 16'h0000 : hits_now;
    end
  end

  // Debounce FSM next state and accept datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    accept_c    = 1'b0;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    units_d     = units_q;
    tens_d      = tens_q;
    hund_d      = hund_q;
    thous_d     = thous_q;
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (res_one) begin
            cand_d = hit_code;
            cnt_d  = 4'd1;
            if (DEB_N <= 4'd1) begin
              accept_c = 1'b1;
              state_d  = PRESSED;
            end else begin
              state_d  = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (res_one && (hit_code == cand_q)) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d >= DEB_N) begin
              accept_c = 1'b1;
              state_d  = PRESSED;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (res_none) begin
            cnt_d   = 4'd1;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (res_none) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d >= DEB_N) state_d = IDLE;
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept_c) begin
      key_valid_d = 1'b1;
      key_code_d  = cand_d;
      if (cand_d <= 4'd9) begin
        thous_d = hund_q;
        hund_d  = tens_q;
        tens_d  = units_q;
        units_d = cand_d;
      end else if (cand_d == 4'hE) begin
        thous_d = 4'd0;
        hund_d  = 4'd0;
        tens_d  = 4'd0;
        units_d = 4'd0;
      end else if (cand_d == 4'hF) begin
        units_d = tens_q;
        tens_d  = hund_q;
        hund_d  = thous_q;
        thous_d = 4'd0;
      end
    end
  end

  // Row synchronizer and scan registers.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      div_q    <= '0;
      cidx_q   <= 2'd0;
      col_q    <= 4'b1110;
      hits_q   <= 16'h0000;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      div_q    <= div_d;
      cidx_q   <= cidx_d;
      col_q    <= col_d;
      hits_q   <= hits_d;
    end
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      units_q     <= 4'd0;
      tens_q      <= 4'd0;
      hund_q      <= 4'd0;
      thous_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      units_q     <= units_d;
      tens_q      <= tens_d;
      hund_q      <= hund_d;
      thous_q     <= thous_d;
    end
  end

  assign col       = col_q;
  assign units     = units_q;
  assign tens      = tens_q;
  assign hund      = hund_q;
  assign thous     = thous_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: doc/keypad_bcd_entry.md
Name: keypad_bcd_entry

Overview:
Scans a 4x4 matrix keypad and debounces key presses. Each accepted key is turned into a 4-digit BCD entry register (thous/hund/tens/units). This is the input-side counterpart of the multiplexed 7-segment display path: it drives columns and reads rows, and its digit outputs connect directly to the display driver's units/tens/hund/thous inputs. It also gives a one-cycle key event with its code, for use by control logic.

Parameters:
SCAN_DIV, 1000, clock cycles each column is held low; minimum 4.
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1, at most 15.

Ports:
clk  input  1  system clock
rst_a  input  1  reset, synchronous, active-high
row  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk
col  output  4  keypad columns, active-low, exactly one bit low at any time
units  output  4  BCD digit 0, least significant
tens  output  4  BCD digit 1
hund  output  4  BCD digit 2
thous  output  4  BCD digit 3, most significant
key_valid  output  1  one-cycle pulse when a press is accepted
key_code  output  4  code of the last accepted key; held between pulses

Behaviour:
- Reset (synchronous, rst_a=1 at a clk edge):
  - col=4'b1110; column index and divider cleared.
  - FSM goes to IDLE; debounce count is 0.
  - units=tens=hund=thous=0; key_valid=0; key_code=0.
  - Asserting rst_a mid-press or mid-debounce abandons that press. A key still held after reset is re-detected from IDLE.
- Row input:
  - row passes through a 2-flop synchronizer before any use.
- Column scan:
  - Column index c steps 0→1→2→3→0; col = ~(1<<c).
  - Each column is held SCAN_DIV cycles, so a full scan is 4*SCAN_DIV cycles.
  - Synchronized rows are sampled on the last cycle of each column's dwell.
  - A key at row r, column c is pressed when synchronized row[r]=0 while column c is driven.
- Key map (row,col)→code:
  - (0,0..3) = 1,2,3,A
  - (1,0..3) = 4,5,6,B
  - (2,0..3) = 7,8,9,C
  - (3,0..3) = *,0,#,D
  - Codes: digits are their value; A–D = 0xA–0xD; * = 0xE; # = 0xF.
- Scan result, formed at the end of column 3 from the 16 samples:
  - NONE: no key seen.
  - ONE(code): exactly one key seen.
  - MULTI: two or more keys seen.
- Debounce FSM, advancing only at scan completion:
  - IDLE:
    - ONE(k): save k, cnt=1, go to DEBOUNCE. If DEBOUNCE_SCANS=1, accept immediately instead.
    - NONE or MULTI: stay in IDLE.
  - DEBOUNCE:
    - ONE(k) with k equal to the saved code: cnt++. When cnt reaches DEBOUNCE_SCANS, accept and go to PRESSED.
    - Any other result: go to IDLE.
  - PRESSED:
    - NONE: cnt=1, go to RELEASE.
    - ONE or MULTI: stay in PRESSED (held or rolled keys are ignored).
  - RELEASE:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - ONE or MULTI: go to PRESSED.
  - Rule: exactly one acceptance per press, no matter how long the key is held.
- Accept action:
  - All effects are registered and visible together on the cycle after the deciding scan-complete edge.
  - key_valid=1 for exactly one cycle, and key_code is updated.
  - Digits 0–9 shift in: thous←hund, hund←tens, tens←units, units←digit. The old thous is discarded.
  - * (0xE) clears all four digits to 0.
  - # (0xF) is backspace: units←tens, tens←hund, hund←thous, thous←0.
  - A–D update key_code and key_valid only; the digits are unchanged.
- Invariant: digit outputs always hold values 0–9.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_SCANS=3; bench keypad model: row[r]=0 if key (r, current col) is held.
- Reset: rst_a high 2 cycles → col=1110, all digits 0, key_valid=0. After release, col steps 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- Press and release 1, 2, 3, 4, each held 6 scans → thous..units = 1,2,3,4; four key_valid pulses; key_code=4. Then press 5 → 2,3,4,5.
- From 2,3,4,5: press # → 0,2,3,4. Press B → digits unchanged, key_code=0xB. Press * → 0,0,0,0, key_code=0xE.
- Bounce and hold:
  - Key 7 present on alternating scans for 6 scans → no key_valid.
  - Key 7 held 20 scans → exactly one key_valid.
  - Release for 2 scans, then re-press → no second pulse.
  - Release for ≥3 scans, then re-press → second pulse.
- Multiple keys:
  - 1 and 5 held together from IDLE → no key_valid.
  - Press 8 until accepted, then add 9 → no further pulse; units=8.
- Reset mid-operation:
  - Assert rst_a during DEBOUNCE of key 6 with digits 0,1,2,3 → digits 0,0,0,0 next cycle.
  - Key 6 still held → a single key_valid 3 full scans after reset release; units=6.
